// File: rtl/mem_wb_stage_pkg.sv
// +------------------------------------------------------------------+
// | mem_wb_stage_pkg : shared widths, load width codes, wb_sel enum    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mem_wb_stage_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
// +------------------------------------------------------------------+
// | mem_wb_stage_if : MEM-side inputs and WB-side outputs of the stage |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface mem_wb_stage_if #(
  parameter int DATA_WIDTH     = mem_wb_stage_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = 5
);

  logic                      stall_i;
  logic                      flush_i;
  logic                      MEM_valid_i;
  logic                      MEM_RegWrite_en_i;
  logic                      MEM_MemRead_en_i;
  logic                      MEM_MemWrite_en_i;
  logic [1:0]                MEM_wb_sel_i;
  logic [2:0]                MEM_funct3_i;
  logic [REG_ADDR_WIDTH-1:0] MEM_rd_addr_i;
  logic [DATA_WIDTH-1:0]     MEM_alu_result_i;
  logic [DATA_WIDTH-1:0]     MEM_pc_plus4_i;
  logic [DATA_WIDTH-1:0]     MEM_wr_data_i;
  logic [DATA_WIDTH-1:0]     mem_rd_data_i;

  logic                      WB_RegWrite_en_o;
  logic [REG_ADDR_WIDTH-1:0] WB_rd_addr_o;
  logic [DATA_WIDTH-1:0]     WB_wr_data_o;
  logic                      WB_MemWrite_en_o;
  logic [DATA_WIDTH-1:0]     WB_addr_o;
  logic [DATA_WIDTH-1:0]     WB_store_data_o;
  logic                      WB_misalign_o;
  logic [DATA_WIDTH-1:0]     WB_badaddr_o;

  modport master (
    output stall_i, flush_i, MEM_valid_i, MEM_RegWrite_en_i, MEM_MemRead_en_i,
           MEM_MemWrite_en_i, MEM_wb_sel_i, MEM_funct3_i, MEM_rd_addr_i,
           MEM_alu_result_i, MEM_pc_plus4_i, MEM_wr_data_i, mem_rd_data_i,
    input  WB_RegWrite_en_o, WB_rd_addr_o, WB_wr_data_o, WB_MemWrite_en_o,
           WB_addr_o, WB_store_data_o, WB_misalign_o, WB_badaddr_o
  );

  modport slave (
    input  stall_i, flush_i, MEM_valid_i, MEM_RegWrite_en_i, MEM_MemRead_en_i,
           MEM_MemWrite_en_i, MEM_wb_sel_i, MEM_funct3_i, MEM_rd_addr_i,
           MEM_alu_result_i, MEM_pc_plus4_i, MEM_wr_data_i, mem_rd_data_i,
    output WB_RegWrite_en_o, WB_rd_addr_o, WB_wr_data_o, WB_MemWrite_en_o,
           WB_addr_o, WB_store_data_o, WB_misalign_o, WB_badaddr_o
  );

endinterface

`default_nettype wire

// File: rtl/mem_wb_stage_load_formatter.sv
// +------------------------------------------------------------------+
// | mem_wb_stage_load_formatter : byte/half/word select and extension  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mem_wb_stage_load_formatter
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = mem_wb_stage_pkg::DATA_WIDTH
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addr_i,
  input  logic [DATA_WIDTH-1:0] raw_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Halfword selection ignores addr[0] so misaligned halves fall back to the aligned one.
  assign sel_byte = raw_i[{addr_i, 3'b000} +: 8];
  assign sel_half = raw_i[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = '0;
    case (funct3_i)
      FUNCT3_LB:  data_o = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      FUNCT3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      FUNCT3_LH:  data_o = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
      FUNCT3_LHU: data_o = {{(DATA_WIDTH-16){1'b0}}, sel_half};
      FUNCT3_LW:  data_o = raw_i;
      default:    data_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// +------------------------------------------------------------------+
// | mem_wb_stage : MEM/WB pipeline register and writeback formatter   |
// | Optional misaligned-load trap: define MISALIGN_TRAP_EN. Rev 1.0   |
// +------------------------------------------------------------------+
`default_nettype none

module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = mem_wb_stage_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);

  logic                      valid_q, regwrite_q, memread_q, memwrite_q;
  wb_sel_e                   wb_sel_q;
  logic [2:0]                funct3_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     addr_q, link_q, store_q, hold_word_q;
  logic                      captured_q;

  logic                      adv_valid;
  logic                      regwrite_d;
  logic [DATA_WIDTH-1:0]     raw_word, fmt_data;

  assign adv_valid = bus.MEM_valid_i & ~bus.flush_i;

`ifdef MISALIGN_TRAP_EN
  logic                  misalign_d, misalign_q;
  logic [DATA_WIDTH-1:0] badaddr_q;

  always_comb begin
    misalign_d = 1'b0;
    if (adv_valid && bus.MEM_MemRead_en_i) begin
      case (bus.MEM_funct3_i)
        FUNCT3_LH, FUNCT3_LHU: misalign_d = bus.MEM_alu_result_i[0];
        FUNCT3_LW:             misalign_d = |bus.MEM_alu_result_i[1:0];
        default:               misalign_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
      badaddr_q  <= '0;
    end else if (!bus.stall_i) begin
      misalign_q <= misalign_d;
      badaddr_q  <= misalign_d ? bus.MEM_alu_result_i : '0;
    end
  end

  assign bus.WB_misalign_o = misalign_q;
  assign bus.WB_badaddr_o  = badaddr_q;
`else
  logic misalign_d;
  assign misalign_d        = 1'b0;
  assign bus.WB_misalign_o = 1'b0;
  assign bus.WB_badaddr_o  = '0;
`endif

  assign regwrite_d = adv_valid & bus.MEM_RegWrite_en_i
                    & (bus.MEM_rd_addr_i != '0) & ~misalign_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      wb_sel_q    <= WB_ALU;
      funct3_q    <= '0;
      rd_q        <= '0;
      addr_q      <= '0;
      link_q      <= '0;
      store_q     <= '0;
      hold_word_q <= '0;
      captured_q  <= 1'b0;
    end else if (bus.stall_i) begin
      // Latch the read word once so the writeback value survives memory moving on.
      if (valid_q && memread_q && !captured_q) begin
        hold_word_q <= bus.mem_rd_data_i;
        captured_q  <= 1'b1;
      end
    end else begin
      valid_q    <= adv_valid;
      regwrite_q <= regwrite_d;
      memread_q  <= adv_valid & bus.MEM_MemRead_en_i;
      memwrite_q <= adv_valid & bus.MEM_MemWrite_en_i;
      wb_sel_q   <= wb_sel_e'(bus.MEM_wb_sel_i);
      funct3_q   <= bus.MEM_funct3_i;
      rd_q       <= bus.MEM_rd_addr_i;
      addr_q     <= bus.MEM_alu_result_i;
      link_q     <= bus.MEM_pc_plus4_i;
      store_q    <= bus.MEM_wr_data_i;
      captured_q <= 1'b0;
    end
  end

  assign raw_word = captured_q ? hold_word_q : bus.mem_rd_data_i;

  mem_wb_stage_load_formatter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_formatter (
    .funct3_i (funct3_q),
    .addr_i   (addr_q[1:0]),
    .raw_i    (raw_word),
    .data_o   (fmt_data)
  );

  always_comb begin
    bus.WB_wr_data_o = '0;
    case (wb_sel_q)
      WB_ALU:  bus.WB_wr_data_o = addr_q;
      WB_MEM:  bus.WB_wr_data_o = fmt_data;
      WB_PC4:  bus.WB_wr_data_o = link_q;
      default: bus.WB_wr_data_o = '0;
    endcase
  end

  assign bus.WB_RegWrite_en_o = regwrite_q;
  assign bus.WB_rd_addr_o     = rd_q;
  assign bus.WB_MemWrite_en_o = memwrite_q;
  assign bus.WB_addr_o        = addr_q;
  assign bus.WB_store_data_o  = store_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// +------------------------------------------------------------------+
// | tb_mem_wb_stage : directed self-checking bench for mem_wb_stage    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_wb_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_wb_stage_if bus_if ();

  mem_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_mem();
    bus_if.MEM_valid_i       = 1'b0;
    bus_if.MEM_RegWrite_en_i = 1'b0;
    bus_if.MEM_MemRead_en_i  = 1'b0;
    bus_if.MEM_MemWrite_en_i = 1'b0;
  endtask

  task automatic set_mem(input logic rw, input logic mr, input logic mw, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] wd);
    bus_if.MEM_valid_i       = 1'b1;
    bus_if.MEM_RegWrite_en_i = rw;
    bus_if.MEM_MemRead_en_i  = mr;
    bus_if.MEM_MemWrite_en_i = mw;
    bus_if.MEM_wb_sel_i      = sel;
    bus_if.MEM_funct3_i      = f3;
    bus_if.MEM_rd_addr_i     = rd;
    bus_if.MEM_alu_result_i  = alu;
    bus_if.MEM_pc_plus4_i    = pc4;
    bus_if.MEM_wr_data_i     = wd;
  endtask

  // Drive one instruction into MEM, clock it into WB, then return MEM to idle.
  task automatic issue(input logic rw, input logic mr, input logic mw, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] wd);
    set_mem(rw, mr, mw, sel, f3, rd, alu, pc4, wd);
    @(posedge clk);
    #1;
    idle_mem();
    bus_if.flush_i = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input logic [31:0] exp);
    issue(1'b1, 1'b1, 1'b0, 2'b01, f3, 5'd5, addr, 32'h0, 32'h0);
    bus_if.mem_rd_data_i = word;
    #1;
    check_eq(tag, bus_if.WB_wr_data_o, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus_if.stall_i          = 1'b0;
    bus_if.flush_i          = 1'b0;
    bus_if.MEM_wb_sel_i     = 2'b00;
    bus_if.MEM_funct3_i     = 3'b000;
    bus_if.MEM_rd_addr_i    = 5'd0;
    bus_if.MEM_alu_result_i = 32'h0;
    bus_if.MEM_pc_plus4_i   = 32'h0;
    bus_if.MEM_wr_data_i    = 32'h0;
    bus_if.mem_rd_data_i    = 32'h0;
    idle_mem();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h0);
    check_eq("rst_rd", {27'h0, bus_if.WB_rd_addr_o}, 32'h0);
    check_eq("rst_wrdata", bus_if.WB_wr_data_o, 32'h0);
    check_eq("rst_memwrite", {31'h0, bus_if.WB_MemWrite_en_o}, 32'h0);
    check_eq("rst_addr", bus_if.WB_addr_o, 32'h0);
    check_eq("rst_store", bus_if.WB_store_data_o, 32'h0);
    check_eq("rst_misalign", {31'h0, bus_if.WB_misalign_o}, 32'h0);
    check_eq("rst_badaddr", bus_if.WB_badaddr_o, 32'h0);
    rst = 1'b0;

    // Load formatting
    load_check("lb_103",  3'b000, 32'h103, 32'h80FF_1234, 32'hFFFF_FF80);
    check_eq("lb_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h1);
    check_eq("lb_rd", {27'h0, bus_if.WB_rd_addr_o}, 32'd5);
    load_check("lbu_103", 3'b100, 32'h103, 32'h80FF_1234, 32'h0000_0080);
    load_check("lb_101",  3'b000, 32'h101, 32'h80FF_1234, 32'h0000_0012);
    load_check("lh_102",  3'b001, 32'h102, 32'h8001_7FFF, 32'hFFFF_8001);
    load_check("lhu_100", 3'b101, 32'h100, 32'h8001_7FFF, 32'h0000_7FFF);
    load_check("lhu_102", 3'b101, 32'h102, 32'h8001_7FFF, 32'h0000_8001);
    load_check("lw_100",  3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_check("bad_f3",  3'b011, 32'h100, 32'hDEAD_BEEF, 32'h0000_0000);

    // Load to x0 never writes
    issue(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd0, 32'h100, 32'h0, 32'h0);
    #1;
    check_eq("x0_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h0);

    // JAL link, ALU and reserved select
    issue(1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 5'd1, 32'h1000, 32'h44, 32'h0);
    #1;
    check_eq("jal_wrdata", bus_if.WB_wr_data_o, 32'h44);
    check_eq("jal_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h1);
    check_eq("jal_rd", {27'h0, bus_if.WB_rd_addr_o}, 32'd1);
    issue(1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 5'd2, 32'h1234_5678, 32'h8, 32'h0);
    #1;
    check_eq("alu_wrdata", bus_if.WB_wr_data_o, 32'h1234_5678);
    issue(1'b1, 1'b0, 1'b0, 2'b11, 3'b000, 5'd2, 32'h1234_5678, 32'h8, 32'h0);
    #1;
    check_eq("rsvd_wrdata", bus_if.WB_wr_data_o, 32'h0);

    // Multi-cycle stall holds the first read word; flush during stall ignored
    issue(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd7, 32'h200, 32'h0, 32'h0);
    bus_if.mem_rd_data_i = 32'h1111_1111;
    bus_if.stall_i       = 1'b1;
    set_mem(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd8, 32'h300, 32'h0, 32'h0);
    #1;
    check_eq("stall0_wrdata", bus_if.WB_wr_data_o, 32'h1111_1111);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      bus_if.mem_rd_data_i = 32'h2222_2222 + i;
      #1;
      check_eq("stall_wrdata", bus_if.WB_wr_data_o, 32'h1111_1111);
      check_eq("stall_rd", {27'h0, bus_if.WB_rd_addr_o}, 32'd7);
    end
    bus_if.flush_i = 1'b1;
    @(posedge clk);
    #1;
    check_eq("stflush_rd", {27'h0, bus_if.WB_rd_addr_o}, 32'd7);
    check_eq("stflush_wrdata", bus_if.WB_wr_data_o, 32'h1111_1111);
    check_eq("stflush_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h1);
    bus_if.flush_i = 1'b0;
    bus_if.stall_i = 1'b0;
    @(posedge clk);
    #1;
    idle_mem();
    bus_if.mem_rd_data_i = 32'h3333_3333;
    #1;
    check_eq("release_rd", {27'h0, bus_if.WB_rd_addr_o}, 32'd8);
    check_eq("release_wrdata", bus_if.WB_wr_data_o, 32'h3333_3333);

    // Flushed store retires as a bubble; normal store returns address and data
    bus_if.flush_i = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h40, 32'h0, 32'hCAFE_F00D);
    #1;
    check_eq("flush_memwrite", {31'h0, bus_if.WB_MemWrite_en_o}, 32'h0);
    issue(1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 5'd0, 32'h40, 32'h0, 32'hCAFE_F00D);
    #1;
    check_eq("st_memwrite", {31'h0, bus_if.WB_MemWrite_en_o}, 32'h1);
    check_eq("st_addr", bus_if.WB_addr_o, 32'h40);
    check_eq("st_data", bus_if.WB_store_data_o, 32'hCAFE_F00D);
    check_eq("st_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h0);

    // Reset in the middle of a stall
    issue(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd9, 32'h104, 32'h0, 32'h5);
    bus_if.mem_rd_data_i = 32'h5555_5555;
    bus_if.stall_i       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rststall_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h0);
    check_eq("rststall_rd", {27'h0, bus_if.WB_rd_addr_o}, 32'h0);
    check_eq("rststall_wrdata", bus_if.WB_wr_data_o, 32'h0);
    check_eq("rststall_addr", bus_if.WB_addr_o, 32'h0);
    check_eq("rststall_store", bus_if.WB_store_data_o, 32'h0);
    rst            = 1'b0;
    bus_if.stall_i = 1'b0;

    // Misaligned LW
    issue(1'b1, 1'b1, 1'b0, 2'b01, 3'b010, 5'd3, 32'h102, 32'h0, 32'h0);
    bus_if.mem_rd_data_i = 32'hAABB_CCDD;
    #1;
`ifdef MISALIGN_TRAP_EN
    check_eq("mis_flag", {31'h0, bus_if.WB_misalign_o}, 32'h1);
    check_eq("mis_badaddr", bus_if.WB_badaddr_o, 32'h102);
    check_eq("mis_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h0);
`else
    check_eq("mis_flag", {31'h0, bus_if.WB_misalign_o}, 32'h0);
    check_eq("mis_badaddr", bus_if.WB_badaddr_o, 32'h0);
    check_eq("mis_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h1);
    check_eq("mis_wrdata", bus_if.WB_wr_data_o, 32'hAABB_CCDD);
`endif
    @(posedge clk);
    #1;
    check_eq("mis_bubble_flag", {31'h0, bus_if.WB_misalign_o}, 32'h0);
    check_eq("mis_bubble_regwrite", {31'h0, bus_if.WB_RegWrite_en_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
